// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO.
//   DefDepth / DefWidth : default FIFO geometry used by uart_tx_fifo
//   tx_state_e          : launcher FSM state encoding
package uart_pkg;

  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefWidth = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StLaunch   = 2'b01,
    StWaitDone = 2'b10
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART transmit FIFO: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data (combinational from rd_addr_i)
module uart_fifo_mem #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [Aw-1:0]    wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [Aw-1:0]    rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter. Bytes are queued through a
// circular buffer and a small launcher FSM pops one byte at a time, pulses
// tx_en for one cycle and waits for the transmitter's tx_done.
// Optional feature: define UART_TX_FIFO_OVF_EN to add a sticky overflow flag.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   wr_data  : byte to enqueue
//   wr_en    : enqueue strobe
//   full     : no free entry
//   empty    : no stored entry
//   count    : number of stored entries
//   tx_d_in  : byte presented to the transmitter
//   tx_en    : one-cycle launch pulse
//   tx_done  : transmitter completion pulse
//   ovf_clr  : clears overflow (UART_TX_FIFO_OVF_EN only)
//   overflow : sticky dropped-write flag (UART_TX_FIFO_OVF_EN only)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         tx_d_in,
  output logic                     tx_en,
`ifdef UART_TX_FIFO_OVF_EN
  input  logic                     ovf_clr,
  output logic                     overflow,
`endif
  input  logic                     tx_done
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam int unsigned Cw = Aw + 1;

  tx_state_e        state_q, state_d;
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [Cw-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tx_d_q, tx_d_d;
  logic [WIDTH-1:0] head_data;
  logic             pop;
  logic             wr_accept;

  assign full    = (count_q == Cw'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign tx_d_in = tx_d_q;
  // Decoded straight from state so it drops the instant reset asserts.
  assign tx_en   = (state_q == StLaunch);

  // A full FIFO still takes a write when the launcher frees a slot this cycle.
  assign wr_accept = wr_en && (!full || pop);

  uart_fifo_mem #(
    .Depth (DEPTH),
    .Width (WIDTH),
    .Aw    (Aw)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_data)
  );

  // Launcher FSM next-state and pop decision.
  always_comb begin
    state_d = state_q;
    tx_d_d  = tx_d_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          tx_d_d  = head_data;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (tx_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_accept ? wr_ptr_q + Aw'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + Aw'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + Cw'(1);
      2'b01:   count_d = count_q - Cw'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_d_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_d_q   <= tx_d_d;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;
  logic wr_drop;

  assign wr_drop  = wr_en && !wr_accept;
  assign overflow = ovf_q;

  // A drop in the same cycle as a clear wins, so no drop goes unreported.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16, WIDTH=8).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] tx_d_in;
  logic       tx_en;
  logic       tx_done;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf_clr;
  logic       overflow;
`endif

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(
    .DEPTH (16),
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_d_in  (tx_d_in),
    .tx_en    (tx_en),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
`endif
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    wr_data = '0;
    wr_en   = 1'b0;
    tx_done = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    #1 rst = 1'b1;
    #1;
    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_tx_d",  32'(tx_d_in), 0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_ovf",   32'(overflow), 0);
`endif
    tick(1);
    rst = 1'b0;

    // Single byte: write, IDLE pop, LAUNCH
    wr_data = 8'hA5; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    chk("lat_c1_count", 32'(count), 1);
    chk("lat_c1_empty", 32'(empty), 0);
    chk("lat_c1_tx_en", 32'(tx_en), 0);
    tick(1);
    chk("lat_c2_tx_en", 32'(tx_en), 1);
    chk("lat_c2_tx_d",  32'(tx_d_in), 32'hA5);
    chk("lat_c2_count", 32'(count), 0);
    chk("lat_c2_empty", 32'(empty), 1);
    tick(1);
    chk("lat_c3_tx_en", 32'(tx_en), 0);
    chk("lat_c3_tx_d",  32'(tx_d_in), 32'hA5);
    pulse_done();
    chk("lat_idle_tx_en", 32'(tx_en), 0);

    // Stray tx_done while idle and empty
    pulse_done();
    chk("stray_tx_en", 32'(tx_en), 0);
    chk("stray_empty", 32'(empty), 1);
    chk("stray_tx_d",  32'(tx_d_in), 32'hA5);
    tick(1);
    chk("stray_tx_en2", 32'(tx_en), 0);

    // Three back-to-back bytes, tx_done 20 cycles after each launch
    wr_data = 8'h01; wr_en = 1'b1;
    tick(1);
    wr_data = 8'h02;
    tick(1);
    chk("seq0_tx_en", 32'(tx_en), 1);
    chk("seq0_tx_d",  32'(tx_d_in), 32'h01);
    wr_data = 8'h03;
    tick(1);
    wr_en = 1'b0;
    chk("seq0_pulse_end", 32'(tx_en), 0);
    chk("seq0_count",     32'(count), 2);
    tick(19);
    pulse_done();
    chk("seq1_pre", 32'(tx_en), 0);
    tick(1);
    chk("seq1_tx_en", 32'(tx_en), 1);
    chk("seq1_tx_d",  32'(tx_d_in), 32'h02);
    chk("seq1_count", 32'(count), 1);
    tick(20);
    chk("seq1_hold", 32'(tx_d_in), 32'h02);
    pulse_done();
    tick(1);
    chk("seq2_tx_en", 32'(tx_en), 1);
    chk("seq2_tx_d",  32'(tx_d_in), 32'h03);
    chk("seq2_empty", 32'(empty), 1);
    tick(20);
    pulse_done();
    tick(1);
    chk("seq_end_tx_en", 32'(tx_en), 0);

    // Fill with tx_done withheld: one byte popped, 16 stored, 18th dropped
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'h10 + 8'(i); wr_en = 1'b1;
      tick(1);
    end
    chk("fill_full",  32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_tx_d",  32'(tx_d_in), 32'h10);
`ifdef UART_TX_FIFO_OVF_EN
    chk("fill_ovf0",  32'(overflow), 0);
`endif
    wr_data = 8'h21;
    tick(1);
    wr_en = 1'b0;
    chk("drop_count", 32'(count), 16);
    chk("drop_full",  32'(full), 1);
`ifdef UART_TX_FIFO_OVF_EN
    chk("drop_ovf",   32'(overflow), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    // Drop and clear together: drop wins
    wr_en = 1'b1; ovf_clr = 1'b1;
    tick(1);
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("ovf_drop_clr", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 0);
`endif

    // Full FIFO, write in the same cycle as the IDLE pop
    pulse_done();
    chk("fp_idle_count", 32'(count), 16);
    chk("fp_idle_tx_en", 32'(tx_en), 0);
    wr_data = 8'h22; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    chk("fp_count", 32'(count), 16);
    chk("fp_full",  32'(full), 1);
    chk("fp_tx_en", 32'(tx_en), 1);
    chk("fp_tx_d",  32'(tx_d_in), 32'h11);

    // Reset during LAUNCH: tx_en falls without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("rl_tx_en",  32'(tx_en), 0);
    chk("rl_count",  32'(count), 0);
    chk("rl_empty",  32'(empty), 1);
    chk("rl_full",   32'(full), 0);
    chk("rl_tx_d",   32'(tx_d_in), 0);
    tick(1);
    rst = 1'b0;

    // Reset in WAIT_DONE with 5 bytes stored
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h31 + 8'(i); wr_en = 1'b1;
      tick(1);
    end
    wr_en = 1'b0;
    chk("rw_count", 32'(count), 5);
    chk("rw_tx_d",  32'(tx_d_in), 32'h31);
    #2 rst = 1'b1;
    #1;
    chk("rw_rst_count", 32'(count), 0);
    chk("rw_rst_empty", 32'(empty), 1);
    chk("rw_rst_tx_en", 32'(tx_en), 0);
    tick(1);
    rst = 1'b0;
    pulse_done();
    chk("rw_done_tx_en", 32'(tx_en), 0);
    chk("rw_done_empty", 32'(empty), 1);
    tick(1);
    chk("rw_done_tx_en2", 32'(tx_en), 0);

    // Fresh byte after reset launches normally
    wr_data = 8'h5A; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    chk("post_count", 32'(count), 1);
    tick(1);
    chk("post_tx_en", 32'(tx_en), 1);
    chk("post_tx_d",  32'(tx_d_in), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter WIDTH, default 8, meaning bits per entry.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_data  in  WIDTH  byte to enqueue.
REQ-006 SHALL have port wr_en  in  1  enqueue strobe, one byte per cycle.
REQ-007 SHALL have port full  out  1  no free entry.
REQ-008 SHALL have port empty  out  1  no stored entry.
REQ-009 SHALL have port count  out  $clog2(DEPTH)+1  stored entries.
REQ-010 SHALL have port tx_d_in  out  WIDTH  byte presented to the transmitter d_in.
REQ-011 SHALL have port tx_en  out  1  one-cycle launch pulse to the transmitter.
REQ-012 SHALL have port tx_done  in  1  transmitter one-cycle completion pulse.
REQ-013 SHALL have ports overflow (out, 1, sticky dropped-write flag) and ovf_clr (in, 1, clears overflow), present only with UART_TX_FIFO_OVF_EN.

Function
REQ-014 SHALL accept a write when wr_en=1 and (full=0 or a pop occurs the same cycle).
REQ-015 SHALL drop a write with wr_en=1, full=1, no same-cycle pop; contents unchanged.
REQ-016 SHALL update count/full/empty one cycle after the accepted write/pop; simultaneous write+pop leaves count unchanged.
REQ-017 SHALL wrap read/write pointers modulo DEPTH without gaps.
REQ-018 SHALL run launcher FSM states IDLE, LAUNCH, WAIT_DONE.
REQ-019 IDLE: if empty=0, latch head byte into tx_d_in, pop it, go LAUNCH.
REQ-020 LAUNCH: drive tx_en=1 for exactly this one cycle, go WAIT_DONE.
REQ-021 WAIT_DONE: hold tx_d_in and tx_en=0 until tx_done=1, then go IDLE.
REQ-022 SHALL hold tx_d_in stable from LAUNCH entry until the next IDLE pop.
REQ-023 SHALL give latency write-into-empty-FIFO to tx_en high of 3 cycles (write, IDLE pop, LAUNCH).
REQ-024 SHALL ignore tx_done outside WAIT_DONE.
REQ-025 SHALL deliver bytes strictly in write order, none duplicated or skipped.

Reset
REQ-026 SHALL on rst=1 immediately set: FSM IDLE, pointers 0, count 0, empty 1, full 0, tx_en 0, tx_d_in 0, overflow 0.
REQ-027 SHALL discard stored and in-flight bytes on reset mid-operation; tx_en falls asynchronously.
REQ-028 SHALL leave storage array contents unreset (not observable).

Configuration
REQ-029 With UART_TX_FIFO_OVF_EN defined SHALL set overflow on any dropped write, hold until ovf_clr=1; same-cycle drop and clear leaves overflow=1.
REQ-030 Without UART_TX_FIFO_OVF_EN SHALL omit overflow/ovf_clr ports and logic; drops silent.

Structure
REQ-031 SHALL take FSM state encodings (IDLE=2'b00, LAUNCH=2'b01, WAIT_DONE=2'b10) and default DEPTH/WIDTH from shared package uart_pkg.
REQ-032 SHALL place the dual-pointer storage array in one sub-module uart_fifo_mem (1 write port, 1 async read port).

Verification
REQ-033 Write 8'hA5 into empty FIFO -> tx_en pulses 3 cycles later, tx_d_in=8'hA5, count back to 0.
REQ-034 Write 8'h01,8'h02,8'h03 back-to-back, tx_done 20 cycles after each tx_en -> three tx_en pulses, bytes in order 01,02,03.
REQ-035 DEPTH=16, tx_done withheld, 18 writes -> full=1 after 17 writes (one popped), 18th dropped, overflow=1 (macro on), ovf_clr clears.
REQ-036 FIFO full, write in same cycle as IDLE pop -> write accepted, count stays 16.
REQ-037 Assert rst in WAIT_DONE with 5 bytes stored -> same cycle tx_en=0, count=0, empty=1; later tx_done ignored.
REQ-038 Stray tx_done pulse in IDLE with empty FIFO -> no state change, no tx_en.
